// File: rtl/uart_mem_arbiter.sv
// uart_mem_arbiter
// Shares one single-port memory between a UART command interface and a CPU.
// A UART request is a one-cycle pulse captured into a pending slot; the CPU
// holds a level request until granted. Ties are resolved round-robin.
//
// Ports
//   clk50MHz, reset_n          clock, asynchronous active-low reset
//   uart_req/we/addr/wdata     UART access pulse and fields
//   uart_rdata, uart_rvalid    UART read result and update pulse
//   uart_busy, uart_overrun    pending flag, sticky dropped-request flag
//   ovr_clr                    clears uart_overrun
//   cpu_req/we/addr/wdata      CPU access, held until cpu_gnt
//   cpu_gnt, cpu_rdata, cpu_rvalid  grant pulse, read result, update pulse
//   mem_en/we/addr/wdata       registered memory command
//   mem_rdata                  memory read data, one cycle after a read command
//
// State    | meaning
// ST_IDLE  | choose a requester and launch its memory command
// ST_ACCESS| memory command active (mem_en=1)
// ST_RESP  | read data on mem_rdata, capture it for the owner
module uart_mem_arbiter #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 7
) (
  input  logic               clk50MHz,
  input  logic               reset_n,
  input  logic               uart_req,
  input  logic               uart_we,
  input  logic [A_WIDTH-1:0] uart_addr,
  input  logic [D_WIDTH-1:0] uart_wdata,
  output logic [D_WIDTH-1:0] uart_rdata,
  output logic               uart_rvalid,
  output logic               uart_busy,
  output logic               uart_overrun,
  input  logic               ovr_clr,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [A_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_wdata,
  output logic               cpu_gnt,
  output logic [D_WIDTH-1:0] cpu_rdata,
  output logic               cpu_rvalid,
  output logic               mem_en,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               last_uart_q, last_uart_d;   // 1: last grant went to UART
  logic               own_uart_q, own_uart_d;     // owner of the access in flight
  logic               busy_q, busy_d;             // doubles as pending-valid
  logic               pend_we_q, pend_we_d;
  logic [A_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [D_WIDTH-1:0] pend_wdata_q, pend_wdata_d;
  logic               ovr_q, ovr_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [A_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [D_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic               cpu_gnt_q, cpu_gnt_d;
  logic [D_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic               cpu_rvalid_q, cpu_rvalid_d;
  logic [D_WIDTH-1:0] uart_rdata_q, uart_rdata_d;
  logic               uart_rvalid_q, uart_rvalid_d;
  logic               grant_uart;

  always_comb begin
    state_d       = state_q;
    last_uart_d   = last_uart_q;
    own_uart_d    = own_uart_q;
    busy_d        = busy_q;
    pend_we_d     = pend_we_q;
    pend_addr_d   = pend_addr_q;
    pend_wdata_d  = pend_wdata_q;
    ovr_d         = ovr_q;
    mem_en_d      = 1'b0;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_gnt_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_rvalid_d  = 1'b0;
    uart_rdata_d  = uart_rdata_q;
    uart_rvalid_d = 1'b0;
    grant_uart    = 1'b0;

    // A pulse arriving while the slot is occupied is lost, including the
    // cycle the slot is being released.
    if (uart_req && !busy_q) begin
      busy_d       = 1'b1;
      pend_we_d    = uart_we;
      pend_addr_d  = uart_addr;
      pend_wdata_d = uart_wdata;
    end

    // Set is evaluated last so it wins over a simultaneous clear.
    if (ovr_clr) ovr_d = 1'b0;
    if (uart_req && busy_q) ovr_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        grant_uart = busy_q && (!cpu_req || !last_uart_q);
        if (grant_uart) begin
          state_d     = ST_ACCESS;
          own_uart_d  = 1'b1;
          last_uart_d = 1'b1;
          mem_en_d    = 1'b1;
          mem_we_d    = pend_we_q;
          mem_addr_d  = pend_addr_q;
          mem_wdata_d = pend_wdata_q;
        end else if (cpu_req) begin
          state_d     = ST_ACCESS;
          own_uart_d  = 1'b0;
          last_uart_d = 1'b0;
          mem_en_d    = 1'b1;
          mem_we_d    = cpu_we;
          mem_addr_d  = cpu_addr;
          mem_wdata_d = cpu_wdata;
          cpu_gnt_d   = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (mem_we_q) begin
          state_d = ST_IDLE;
          if (own_uart_q) busy_d = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (own_uart_q) begin
          uart_rdata_d  = mem_rdata;
          uart_rvalid_d = 1'b1;
          busy_d        = 1'b0;
        end else begin
          cpu_rdata_d  = mem_rdata;
          cpu_rvalid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      last_uart_q   <= 1'b0;
      own_uart_q    <= 1'b0;
      busy_q        <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_wdata_q  <= '0;
      ovr_q         <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_gnt_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      cpu_rvalid_q  <= 1'b0;
      uart_rdata_q  <= '0;
      uart_rvalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_uart_q   <= last_uart_d;
      own_uart_q    <= own_uart_d;
      busy_q        <= busy_d;
      pend_we_q     <= pend_we_d;
      pend_addr_q   <= pend_addr_d;
      pend_wdata_q  <= pend_wdata_d;
      ovr_q         <= ovr_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_gnt_q     <= cpu_gnt_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      uart_rdata_q  <= uart_rdata_d;
      uart_rvalid_q <= uart_rvalid_d;
    end
  end

  assign uart_rdata   = uart_rdata_q;
  assign uart_rvalid  = uart_rvalid_q;
  assign uart_busy    = busy_q;
  assign uart_overrun = ovr_q;
  assign cpu_gnt      = cpu_gnt_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign cpu_rvalid   = cpu_rvalid_q;
  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_uart_mem_arbiter.sv
// Directed bench for uart_mem_arbiter with a behavioural single-port memory.
module tb_uart_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        uart_req, uart_we, ovr_clr;
  logic [6:0]  uart_addr;
  logic [31:0] uart_wdata, uart_rdata;
  logic        uart_rvalid, uart_busy, uart_overrun;
  logic        cpu_req, cpu_we;
  logic [6:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_gnt, cpu_rvalid;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] mem_model [0:127];

  int checks = 0;
  int errors = 0;
  int n_cpu, n_uart, n_same, prev_owner, owner;

  uart_mem_arbiter #(.D_WIDTH(32), .A_WIDTH(7)) dut (
    .clk50MHz(clk), .reset_n(reset_n),
    .uart_req(uart_req), .uart_we(uart_we), .uart_addr(uart_addr),
    .uart_wdata(uart_wdata), .uart_rdata(uart_rdata), .uart_rvalid(uart_rvalid),
    .uart_busy(uart_busy), .uart_overrun(uart_overrun), .ovr_clr(ovr_clr),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    uart_req = 1'b0; uart_we = 1'b0; uart_addr = '0; uart_wdata = '0; ovr_clr = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

    // Reset values
    tick();
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_cpu_gnt", cpu_gnt, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_uart_rvalid", uart_rvalid, 0);
    check("rst_uart_rdata", uart_rdata, 0);
    check("rst_uart_busy", uart_busy, 0);
    check("rst_uart_overrun", uart_overrun, 0);
    reset_n = 1'b1;

    // CPU write 0x05 <- DEADBEEF, requested in the first cycle after reset
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h05; cpu_wdata = 32'hDEADBEEF;
    tick();
    check("cwr_mem_en", mem_en, 1);
    check("cwr_mem_we", mem_we, 1);
    check("cwr_mem_addr", mem_addr, 32'h05);
    check("cwr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("cwr_cpu_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    tick();
    check("cwr_idle_mem_en", mem_en, 0);
    check("cwr_idle_gnt", cpu_gnt, 0);

    // Preload 0x10 <- 12345678 through the CPU
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h10; cpu_wdata = 32'h12345678;
    tick();
    check("cwr2_gnt", cpu_gnt, 1);
    cpu_req = 1'b0;
    tick();

    // CPU read 0x10: mem_en at N+1, rvalid at N+3
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h10;
    tick();
    check("crd_mem_en", mem_en, 1);
    check("crd_mem_we", mem_we, 0);
    check("crd_mem_addr", mem_addr, 32'h10);
    cpu_req = 1'b0;
    tick();
    check("crd_resp_rvalid", cpu_rvalid, 0);
    check("crd_resp_mem_en", mem_en, 0);
    tick();
    check("crd_rvalid", cpu_rvalid, 1);
    check("crd_rdata", cpu_rdata, 32'h12345678);
    tick();
    check("crd_rvalid_pulse", cpu_rvalid, 0);
    check("crd_rdata_hold", cpu_rdata, 32'h12345678);

    // Round robin from reset: first tie goes to UART
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    uart_req = 1'b1; uart_we = 1'b1; uart_addr = 7'h20; uart_wdata = 32'hA5A5A5A5;
    tick();
    uart_req = 1'b0;
    check("rr_busy_set", uart_busy, 1);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h21; cpu_wdata = 32'h11111111;
    tick();
    check("rr1_mem_en", mem_en, 1);
    check("rr1_mem_addr", mem_addr, 32'h20);
    check("rr1_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    check("rr1_cpu_gnt", cpu_gnt, 0);
    tick();
    check("rr1_busy_clr", uart_busy, 0);
    check("rr1_idle_mem_en", mem_en, 0);
    tick();
    check("rr1_cpu_gnt_after", cpu_gnt, 1);
    check("rr1_cpu_addr", mem_addr, 32'h21);
    cpu_req = 1'b0;
    uart_req = 1'b1; uart_addr = 7'h22; uart_wdata = 32'h22222222;
    tick();
    uart_req = 1'b0;
    check("rr2_idle_mem_en", mem_en, 0);
    tick();
    check("rr2_uart_addr", mem_addr, 32'h22);
    check("rr2_uart_gnt", cpu_gnt, 0);
    tick();
    uart_req = 1'b1; uart_addr = 7'h23; uart_wdata = 32'h33333333;
    tick();
    uart_req = 1'b0;
    cpu_req = 1'b1; cpu_addr = 7'h24; cpu_wdata = 32'h44444444;
    tick();
    // Last grant was UART, so this tie goes to CPU
    check("rr3_cpu_gnt", cpu_gnt, 1);
    check("rr3_cpu_addr", mem_addr, 32'h24);
    cpu_req = 1'b0;
    tick();
    tick();
    check("rr3_uart_mem_en", mem_en, 1);
    check("rr3_uart_addr", mem_addr, 32'h23);

    // Overrun: request during the completing ACCESS cycle is dropped
    uart_req = 1'b1; uart_we = 1'b1; uart_addr = 7'h7F; uart_wdata = 32'hFFFFFFFF;
    tick();
    uart_req = 1'b0;
    check("ovr_set", uart_overrun, 1);
    check("ovr_not_captured", uart_busy, 0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr", uart_overrun, 0);
    check("ovr_no_access", mem_en, 0);
    uart_req = 1'b1; uart_we = 1'b0; uart_addr = 7'h05;
    tick();
    check("urd_busy", uart_busy, 1);
    uart_req = 1'b1; uart_we = 1'b1; uart_addr = 7'h7E; ovr_clr = 1'b1;
    tick();
    uart_req = 1'b0; ovr_clr = 1'b0;
    check("ovr_set_wins", uart_overrun, 1);
    check("urd_mem_en", mem_en, 1);
    check("urd_mem_we", mem_we, 0);
    check("urd_mem_addr", mem_addr, 32'h05);
    tick();
    check("urd_resp_rvalid", uart_rvalid, 0);
    tick();
    check("urd_rvalid", uart_rvalid, 1);
    check("urd_rdata", uart_rdata, 32'hDEADBEEF);
    check("urd_busy_clr", uart_busy, 0);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    check("ovr_clr2", uart_overrun, 0);
    check("urd_rvalid_pulse", uart_rvalid, 0);

    // Reset in the ACCESS cycle of a UART read
    uart_req = 1'b1; uart_we = 1'b0; uart_addr = 7'h10;
    tick();
    uart_req = 1'b0;
    tick();
    check("rsta_mem_en_before", mem_en, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rsta_mem_en", mem_en, 0);
    check("rsta_busy", uart_busy, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rsta_no_rvalid", uart_rvalid, 0);
    end
    check("rsta_rdata", uart_rdata, 0);

    // CPU holds its request; UART pulses every 4 cycles
    n_cpu = 0; n_uart = 0; n_same = 0; prev_owner = -1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h30; cpu_wdata = 32'hC0C0C0C0;
    uart_we = 1'b1; uart_addr = 7'h31; uart_wdata = 32'h0B0B0B0B;
    for (int i = 0; i < 20; i++) begin
      uart_req = (i % 4 == 0);
      tick();
      if (mem_en) begin
        owner = cpu_gnt ? 0 : 1;
        if (owner == prev_owner) n_same++;
        prev_owner = owner;
        if (owner == 0) n_cpu++;
        else            n_uart++;
      end
    end
    uart_req = 1'b0; cpu_req = 1'b0;
    check("fair_cpu_count", n_cpu, 5);
    check("fair_uart_count", n_uart, 5);
    check("fair_alternate", n_same, 0);
    check("fair_no_overrun", uart_overrun, 0);
    tick();
    check("fair_idle_busy", uart_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
